risc_mc_ctrl: RTL and testbench
===============================

Name: risc_mc_ctrl

Overview:
Main control FSM for the multi-cycle RISC-V datapath. It sequences fetch, decode, execute, memory and writeback over shared ALU/memory/register-file resources. It drives every datapath select, including imm_src for the immediate generator. It waits on a single-cycle-pulse memory ready handshake.

Parameters:
none (encodings fixed in package)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
opcode  input  7  instr[6:0] from instruction register (stable after FETCH)
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes current access this cycle
pc_write  output  1  PC load enable = pc_update | (branch & zero)
adr_src  output  1  0=PC, 1=result bus
mem_req  output  1  memory access request
mem_write  output  1  store enable (qualifies mem_req)
ir_write  output  1  IR/old_pc load enable
reg_write  output  1  register file write enable
result_src  output  2  00=alu_out, 01=read data, 10=alu_result
alu_src_a  output  2  00=PC, 01=old_pc, 10=rd1
alu_src_b  output  2  00=rd2, 01=imm, 10=const 4
alu_op  output  2  00=add, 01=sub, 10=funct-decoded
imm_src  output  2  00=I, 01=S, 10=B, 11=J
state_o  output  4  current state (debug)
illegal  output  1  sticky illegal-opcode flag (feature only, else tied 0)

Behaviour:
- Clock/reset: one clock; reset synchronous, active-high. On rst, state=FETCH and illegal=0.
- Outputs are Moore, decoded from state and opcode. pc_write is the only exception: it also depends on zero.
- Every output not listed for a state is 0. In FETCH immediately after reset: adr_src=0, mem_req=1, other enables 0 until mem_ready.
- Opcodes: LW=0000011, SW=0100011, R=0110011, I=0010011, BEQ=1100011, JAL=1101111.
- FETCH:
  - mem_req=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10.
  - ir_write=pc_update=mem_ready.
  - Advance to DECODE only when mem_ready=1; otherwise hold.
- DECODE:
  - a=01, b=01, alu_op=00; imm_src=11 if JAL else 10.
  - Next state: LW/SW->MEMADR, R->EXECR, I->EXECI, BEQ->BEQ, JAL->JAL, else->FETCH.
- MEMADR: a=10, b=01, alu_op=00; imm_src=01 if SW else 00. LW->MEMREAD, SW->MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1, result_src=00. Hold until mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1. Next FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1, result_src=00. Hold until mem_ready, then FETCH.
- EXECR: a=10, b=00, alu_op=10. Next ALUWB.
- EXECI: a=10, b=01, alu_op=10, imm_src=00. Next ALUWB.
- ALUWB: result_src=00, reg_write=1. Next FETCH.
- BEQ: a=10, b=00, alu_op=01, result_src=00, branch=1; pc_write=zero. Next FETCH.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_update=1. Next ALUWB (writes rd=old_pc+4).
- Memory handshake:
  - mem_req and mem_write stay high across wait cycles.
  - mem_ready while mem_req=0 is ignored.
- Reset mid-op: rst has priority over all transitions. It drops mem_req/mem_write and all enables on the next edge.
- Per-instruction latency with mem_ready=1 at every request:
  - LW 5 cycles.
  - SW, R, I, JAL 4 cycles.
  - BEQ 3 cycles.

Optional Feature:
RISC_CTRL_TRAP_EN:
- Defined: an unknown opcode in DECODE goes to TRAP. TRAP holds all enables 0 and sets illegal=1. Only rst leaves TRAP or clears illegal.
- Undefined: an unknown opcode returns to FETCH as a NOP, and illegal is tied 0.

Decomposition:
- Package risc_ctrl_pkg holds:
  - state enum, 4-bit;
  - opcode localparams;
  - imm_src, alu_src_a/b, result_src and alu_op encodings, shared with the immediate generator and datapath.
- Sub-module risc_ctrl_outdec: combinational (state, opcode) -> control word. The FSM keeps only the state register and next-state logic.

Test Plan:
- Reset: rst=1 for 2 cycles mid-MEMWRITE -> state_o=FETCH, mem_write=0, reg_write=0 on the next edge.
- LW (opcode 0000011), mem_ready always 1 -> states FETCH, DECODE, MEMADR (imm_src=00), MEMREAD (adr_src=1), MEMWB (reg_write=1, result_src=01); back to FETCH after 5 cycles.
- SW with mem_ready low 3 cycles in MEMWRITE -> mem_req=mem_write=1 held 4 cycles, imm_src=01 in MEMADR, then FETCH.
- BEQ zero=1 vs zero=0 -> pc_write=1 vs 0 in BEQ; imm_src=10 in DECODE; 3 cycles total.
- JAL (1101111) -> imm_src=11 in DECODE, pc_write=1 in JAL, reg_write=1 in ALUWB.
- Opcode 1111111:
  - with RISC_CTRL_TRAP_EN -> TRAP, illegal=1 sticky through 10 cycles, cleared only by rst;
  - without it -> FETCH after DECODE, illegal=0.

Source files
------------

// File: rtl/risc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control path: FSM states,
// opcodes and the datapath select codes used by the immediate generator,
// ALU source muxes and result mux.
package risc_ctrl_pkg;

    // FSM states (4-bit, exported on state_o for debug)
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECR    = 4'd6,
        ST_EXECI    = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BEQ      = 4'd9,
        ST_JAL      = 4'd10,
        ST_TRAP     = 4'd11
    } state_t;

    // Opcodes (instr[6:0])
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // Immediate generator format select
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // ALU source A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    // ALU source B select
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result bus select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // ALU operation class
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // Full control word produced by the output decoder
    typedef struct packed {
        logic       adr_src;
        logic       mem_req;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       pc_update;
        logic       branch;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] imm_src;
    } ctrl_t;

endpackage

// File: rtl/risc_ctrl_outdec.sv
// Combinational Moore output decoder: (state, opcode) -> control word.
// mem_ready only qualifies the FETCH-state IR/PC load strobes.
module risc_ctrl_outdec
    import risc_ctrl_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic [6:0] opcode_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    // Decode the control word for the current state; unlisted fields stay 0
    always_comb begin
        // NOTE: assigning the whole word first keeps every path fully specified, so no latch is inferred.
        ctrl_o = '0;
        case (state_t'(state_i))
            ST_FETCH: begin
                ctrl_o.mem_req    = 1'b1;
                ctrl_o.adr_src    = 1'b0;
                ctrl_o.alu_src_a  = SRCA_PC;
                ctrl_o.alu_src_b  = SRCB_FOUR;
                ctrl_o.alu_op     = ALU_ADD;
                ctrl_o.result_src = RES_ALURES;
                ctrl_o.ir_write   = mem_ready_i;
                ctrl_o.pc_update  = mem_ready_i;
            end
            ST_DECODE: begin
                ctrl_o.alu_src_a = SRCA_OLDPC;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.imm_src   = (opcode_i == OP_JAL) ? IMM_J : IMM_B;
            end
            ST_MEMADR: begin
                ctrl_o.alu_src_a = SRCA_RD1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.imm_src   = (opcode_i == OP_SW) ? IMM_S : IMM_I;
            end
            ST_MEMREAD: begin
                ctrl_o.mem_req    = 1'b1;
                ctrl_o.adr_src    = 1'b1;
                ctrl_o.result_src = RES_ALUOUT;
            end
            ST_MEMWB: begin
                ctrl_o.result_src = RES_RDATA;
                ctrl_o.reg_write  = 1'b1;
            end
            ST_MEMWRITE: begin
                ctrl_o.mem_req    = 1'b1;
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.adr_src    = 1'b1;
                ctrl_o.result_src = RES_ALUOUT;
            end
            ST_EXECR: begin
                ctrl_o.alu_src_a = SRCA_RD1;
                ctrl_o.alu_src_b = SRCB_RD2;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            ST_EXECI: begin
                ctrl_o.alu_src_a = SRCA_RD1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_FUNCT;
                ctrl_o.imm_src   = IMM_I;
            end
            ST_ALUWB: begin
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.reg_write  = 1'b1;
            end
            ST_BEQ: begin
                ctrl_o.alu_src_a  = SRCA_RD1;
                ctrl_o.alu_src_b  = SRCB_RD2;
                ctrl_o.alu_op     = ALU_SUB;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.branch     = 1'b1;
            end
            ST_JAL: begin
                ctrl_o.alu_src_a  = SRCA_OLDPC;
                ctrl_o.alu_src_b  = SRCB_FOUR;
                ctrl_o.alu_op     = ALU_ADD;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.pc_update  = 1'b1;
            end
            default: ctrl_o = '0;  // TRAP and unused codes: all enables off
        endcase
    end

endmodule

// File: rtl/risc_mc_ctrl.sv
// Main control FSM for the multi-cycle RISC-V datapath.
// Holds the state register and next-state logic; outputs come from
// risc_ctrl_outdec. Optional build macro RISC_CTRL_TRAP_EN routes unknown
// opcodes to a sticky TRAP state with the illegal flag; without it they
// retire as NOPs and illegal is tied 0.
module risc_mc_ctrl
    import risc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_req,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] imm_src,
    output logic [3:0] state_o,
    output logic       illegal
);

    state_t state_q, state_d;
    ctrl_t  ctrl;

    // State register; rst overrides every transition
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
        if (rst) state_q <= ST_FETCH;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_R:         state_d = ST_EXECR;
                    OP_I:         state_d = ST_EXECI;
                    OP_BEQ:       state_d = ST_BEQ;
                    OP_JAL:       state_d = ST_JAL;
`ifdef RISC_CTRL_TRAP_EN
                    default:      state_d = ST_TRAP;
`else
                    default:      state_d = ST_FETCH;
`endif
                endcase
            end
            ST_MEMADR:   state_d = (opcode == OP_SW) ? ST_MEMWRITE : ST_MEMREAD;
            ST_MEMREAD:  if (mem_ready) state_d = ST_MEMWB;
            ST_MEMWB:    state_d = ST_FETCH;
            ST_MEMWRITE: if (mem_ready) state_d = ST_FETCH;
            ST_EXECR:    state_d = ST_ALUWB;
            ST_EXECI:    state_d = ST_ALUWB;
            ST_ALUWB:    state_d = ST_FETCH;
            ST_BEQ:      state_d = ST_FETCH;
            ST_JAL:      state_d = ST_ALUWB;
`ifdef RISC_CTRL_TRAP_EN
            ST_TRAP:     state_d = ST_TRAP;
`endif
            default:     state_d = ST_FETCH;
        endcase
    end

    risc_ctrl_outdec u_outdec (
        .state_i     (state_q),
        .opcode_i    (opcode),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

`ifdef RISC_CTRL_TRAP_EN
    logic illegal_q, illegal_d;

    // Sticky illegal flag: set on entry to TRAP, cleared only by rst
    always_comb illegal_d = illegal_q | (state_d == ST_TRAP);

    // Illegal flag register
    always_ff @(posedge clk) begin
        if (rst) illegal_q <= 1'b0;
        else     illegal_q <= illegal_d;
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    assign pc_write   = ctrl.pc_update | (ctrl.branch & zero);
    assign adr_src    = ctrl.adr_src;
    assign mem_req    = ctrl.mem_req;
    assign mem_write  = ctrl.mem_write;
    assign ir_write   = ctrl.ir_write;
    assign reg_write  = ctrl.reg_write;
    assign result_src = ctrl.result_src;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign imm_src    = ctrl.imm_src;
    assign state_o    = state_q;

endmodule

// File: tb/tb_risc_mc_ctrl.sv
// Directed self-checking bench for risc_mc_ctrl. Expected values are
// hand-derived from the control sequencing of each instruction class.
module tb_risc_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_req, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
    logic [3:0] state_o;
    logic       illegal;

    int checks = 0;
    int errors = 0;

    // State codes as seen on state_o
    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
                           S_MEMREAD = 4'd3, S_MEMWB = 4'd4, S_MEMWRITE = 4'd5,
                           S_EXECR = 4'd6, S_EXECI = 4'd7, S_ALUWB = 4'd8,
                           S_BEQ = 4'd9, S_JAL = 4'd10, S_TRAP = 4'd11;

    always #5 clk = ~clk;

    risc_mc_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .imm_src    (imm_src),
        .state_o    (state_o),
        .illegal    (illegal)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; opcode = 7'b0; zero = 1'b0; mem_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;

        // Reset state: FETCH requesting, nothing else enabled
        check("rst_state",    8'(state_o),   8'(S_FETCH));
        check("rst_mem_req",  8'(mem_req),   8'd1);
        check("rst_adr_src",  8'(adr_src),   8'd0);
        check("rst_ir_write", 8'(ir_write),  8'd0);
        check("rst_pc_write", 8'(pc_write),  8'd0);
        check("rst_reg_write",8'(reg_write), 8'd0);
        check("rst_srcb",     8'(alu_src_b), 8'd2);
        check("rst_res",      8'(result_src),8'd2);
        check("rst_illegal",  8'(illegal),   8'd0);

        // FETCH holds without mem_ready
        tick();
        check("fetch_hold", 8'(state_o), 8'(S_FETCH));

        // ---- LW ----
        opcode = 7'b0000011; mem_ready = 1'b1; #1;
        check("lw_ir_write", 8'(ir_write), 8'd1);
        check("lw_pc_write", 8'(pc_write), 8'd1);
        tick();
        check("lw_decode",   8'(state_o), 8'(S_DECODE));
        check("lw_dec_imm",  8'(imm_src), 8'd2);
        check("lw_dec_srca", 8'(alu_src_a), 8'd1);
        check("lw_dec_req",  8'(mem_req), 8'd0);
        tick();
        check("lw_memadr",   8'(state_o), 8'(S_MEMADR));
        check("lw_adr_imm",  8'(imm_src), 8'd0);
        check("lw_adr_srca", 8'(alu_src_a), 8'd2);
        tick();
        check("lw_memread",  8'(state_o), 8'(S_MEMREAD));
        check("lw_rd_adr",   8'(adr_src), 8'd1);
        check("lw_rd_req",   8'(mem_req), 8'd1);
        check("lw_rd_wr",    8'(mem_write), 8'd0);
        tick();
        check("lw_memwb",    8'(state_o), 8'(S_MEMWB));
        check("lw_wb_rw",    8'(reg_write), 8'd1);
        check("lw_wb_res",   8'(result_src), 8'd1);
        tick();
        check("lw_done",     8'(state_o), 8'(S_FETCH));

        // ---- SW with 3 wait cycles ----
        opcode = 7'b0100011; mem_ready = 1'b1;
        tick();
        check("sw_decode", 8'(state_o), 8'(S_DECODE));
        mem_ready = 1'b0;  // ignored outside a request
        tick();
        check("sw_memadr", 8'(state_o), 8'(S_MEMADR));
        check("sw_adr_imm",8'(imm_src), 8'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("sw_wait_state", 8'(state_o), 8'(S_MEMWRITE));
            check("sw_wait_req",   8'(mem_req), 8'd1);
            check("sw_wait_wr",    8'(mem_write), 8'd1);
            tick();
        end
        mem_ready = 1'b1; #1;
        check("sw_last_wr",  8'(mem_write), 8'd1);
        check("sw_last_adr", 8'(adr_src), 8'd1);
        tick();
        check("sw_done",     8'(state_o), 8'(S_FETCH));
        check("sw_done_wr",  8'(mem_write), 8'd0);

        // ---- Reset in the middle of MEMWRITE ----
        tick(); tick();  // DECODE, MEMADR (opcode still SW)
        mem_ready = 1'b0;
        tick();
        check("rstmid_pre", 8'(state_o), 8'(S_MEMWRITE));
        rst = 1'b1;
        tick();
        check("rstmid_state", 8'(state_o), 8'(S_FETCH));
        check("rstmid_wr",    8'(mem_write), 8'd0);
        check("rstmid_rw",    8'(reg_write), 8'd0);
        mem_ready = 1'b1;  // rst wins over the FETCH transition
        tick();
        check("rstmid_hold", 8'(state_o), 8'(S_FETCH));
        rst = 1'b0;

        // ---- R-type ----
        opcode = 7'b0110011;
        tick();
        tick();
        check("r_exec",    8'(state_o), 8'(S_EXECR));
        check("r_srcb",    8'(alu_src_b), 8'd0);
        check("r_aluop",   8'(alu_op), 8'd2);
        tick();
        check("r_aluwb",   8'(state_o), 8'(S_ALUWB));
        check("r_rw",      8'(reg_write), 8'd1);
        tick();
        check("r_done",    8'(state_o), 8'(S_FETCH));

        // ---- I-type ----
        opcode = 7'b0010011;
        tick(); tick();
        check("i_exec",  8'(state_o), 8'(S_EXECI));
        check("i_srcb",  8'(alu_src_b), 8'd1);
        check("i_imm",   8'(imm_src), 8'd0);
        tick();
        check("i_aluwb", 8'(state_o), 8'(S_ALUWB));
        tick();

        // ---- BEQ: 3 cycles, pc_write follows zero ----
        opcode = 7'b1100011; zero = 1'b1;
        tick();
        check("beq_dec_imm", 8'(imm_src), 8'd2);
        check("beq_dec_pcw", 8'(pc_write), 8'd0);
        tick();
        check("beq_state",   8'(state_o), 8'(S_BEQ));
        check("beq_aluop",   8'(alu_op), 8'd1);
        check("beq_pcw_z1",  8'(pc_write), 8'd1);
        zero = 1'b0; #1;
        check("beq_pcw_z0",  8'(pc_write), 8'd0);
        tick();
        check("beq_done",    8'(state_o), 8'(S_FETCH));

        // ---- JAL ----
        opcode = 7'b1101111; zero = 1'b0;
        tick();
        check("jal_dec_imm", 8'(imm_src), 8'd3);
        tick();
        check("jal_state",   8'(state_o), 8'(S_JAL));
        check("jal_pcw",     8'(pc_write), 8'd1);
        check("jal_srca",    8'(alu_src_a), 8'd1);
        check("jal_srcb",    8'(alu_src_b), 8'd2);
        tick();
        check("jal_aluwb",   8'(state_o), 8'(S_ALUWB));
        check("jal_rw",      8'(reg_write), 8'd1);
        tick();
        check("jal_done",    8'(state_o), 8'(S_FETCH));

        // ---- Unknown opcode ----
        opcode = 7'b1111111;
        tick();
        check("ill_decode", 8'(state_o), 8'(S_DECODE));
        tick();
`ifdef RISC_CTRL_TRAP_EN
        check("ill_trap",   8'(state_o), 8'(S_TRAP));
        for (int i = 0; i < 10; i++) begin
            check("ill_sticky", 8'(illegal), 8'd1);
            check("ill_req",    8'(mem_req), 8'd0);
            tick();
        end
        check("ill_still_trap", 8'(state_o), 8'(S_TRAP));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("ill_cleared", 8'(illegal), 8'd0);
        check("ill_fetch",   8'(state_o), 8'(S_FETCH));
`else
        check("ill_nop_fetch", 8'(state_o), 8'(S_FETCH));
        check("ill_flag",      8'(illegal), 8'd0);
        check("ill_req",       8'(mem_req), 8'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
